// File: rtl/unified_mem_arb_pkg.sv
// unified_mem_arb_pkg: shared state encoding, requester ids and counter width for the unified memory arbiter
package unified_mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D = 1'b1;
  localparam int CNT_W = 4;
endpackage

// File: rtl/mem_lat_counter.sv
// mem_lat_counter: loadable down-counter with zero flag that times out the memory latency
module mem_lat_counter
  import unified_mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] count;
  // load wins over decrement; the count parks at zero instead of wrapping
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (load) count <= load_val;
    else if (en && count != '0) count <= count - 1'b1;
  assign zero = count == '0;
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one fixed-latency memory between IF and data ports; UNIFIED_MEM_ARB_ROUND_ROBIN_EN selects round-robin on collisions
module unified_mem_arbiter
  import unified_mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);
  state_t state, state_nx;
  logic owner, lat_we, grant_d, take, done, zero;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  assign take = state == IDLE && (if_req || d_req);
  assign done = state == WAIT && zero;
`ifdef UNIFIED_MEM_ARB_ROUND_ROBIN_EN
  logic last_grant;
  assign grant_d = d_req && (!if_req || last_grant == REQ_IF);
  // remember who won the most recent grant so a collision favours the other port
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_grant <= REQ_IF;
    else if (take) last_grant <= grant_d ? REQ_D : REQ_IF;
`else
  assign grant_d = d_req;
`endif
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // next state: one ISSUE cycle, then WAIT until the latency counter hits zero
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = take ? ISSUE : IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = zero ? IDLE : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  // capture the winner at grant so requesters may change their inputs afterwards
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      owner <= REQ_IF;
      lat_we <= 1'b0;
      lat_addr <= '0;
      lat_wdata <= '0;
    end else if (take) begin
      owner <= grant_d ? REQ_D : REQ_IF;
      lat_we <= grant_d && d_we;
      lat_addr <= grant_d ? d_addr : if_addr;
      lat_wdata <= grant_d ? d_wdata : '0;
    end
  mem_lat_counter u_cnt (
    .clk(clk),
    .reset(reset),
    .load(state == ISSUE),
    .en(state == WAIT),
    .load_val(CNT_W'(MEM_LATENCY - 1)),
    .zero(zero)
  );
  assign mem_en = state == ISSUE;
  assign mem_we = mem_en && lat_we;
  assign mem_addr = mem_en ? lat_addr : '0;
  assign mem_wdata = mem_en ? lat_wdata : '0;
  assign if_ready = done && owner == REQ_IF;
  assign d_ready = done && owner == REQ_D;
  assign if_rdata = if_ready ? mem_rdata : '0;
  assign d_rdata = d_ready && !lat_we ? mem_rdata : '0;
  assign busy = state != IDLE;
  assign grant_id = owner;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: scoreboard bench for unified_mem_arbiter at latencies 2, 1 and 15
module tb_unified_mem_arbiter;
  typedef struct {
    int inst;
    bit port;
    int cyc;
    logic [31:0] data;
  } exp_t;
  typedef struct {
    int inst;
    int cyc;
    bit we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } iss_t;
  exp_t rq[$];
  iss_t iq[$];
  int nvec = 0, nerr = 0, cyc = 0;
  logic clk = 0, reset = 0;
  logic [2:0] if_req, if_ready, d_req, d_we, d_ready, mem_en, mem_we, busy, grant_id;
  logic [31:0] if_addr[3], if_rdata[3], d_addr[3], d_wdata[3], d_rdata[3];
  logic [31:0] mem_addr[3], mem_wdata[3], mem_rdata[3];
  always #5 clk = ~clk;
  // cycle index; cycle k is the interval following the k-th rising edge
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] rom(logic [31:0] a);
    case (a)
      32'h40:  return 32'h00A00093;
      32'h44:  return 32'h00B00113;
      32'h80:  return 32'hCAFEF00D;
      32'h100: return 32'h12345678;
      default: return 32'h0;
    endcase
  endfunction
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int L = g == 0 ? 2 : g == 1 ? 1 : 15;
    logic [4:0] k = 0;
    logic [31:0] q = 0;
    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]), .if_ready(if_ready[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_rdata(d_rdata[g]), .d_ready(d_ready[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]), .busy(busy[g]), .grant_id(grant_id[g])
    );
    // memory model: data only valid exactly L cycles after the issue cycle, junk otherwise
    always @(posedge clk)
      if (mem_en[g]) begin
        k <= 5'(L);
        q <= mem_we[g] ? 32'hFFFF0000 : rom(mem_addr[g]);
      end else if (k != 0) k <= k - 1;
    assign mem_rdata[g] = k == 1 ? q : 32'hBAD0BAD0;
  end
  task automatic chk_ready(int g, bit p, logic [31:0] d);
    exp_t e;
    nvec++;
    if (rq.size() == 0) begin
      nerr++;
      $display("FAIL ready: unexpected ready inst %0d port %0d cycle %0d", g, p, cyc);
    end else begin
      e = rq.pop_front();
      if (e.inst != g || e.port != p || e.cyc != cyc || e.data !== d || grant_id[g] !== p) begin
        nerr++;
        $display("FAIL ready: got inst %0d port %0d cycle %0d data %h grant %0d, expected inst %0d port %0d cycle %0d data %h",
                 g, p, cyc, d, grant_id[g], e.inst, e.port, e.cyc, e.data);
      end
    end
  endtask
  task automatic chk_issue(int g);
    iss_t i;
    nvec++;
    if (iq.size() == 0) begin
      nerr++;
      $display("FAIL issue: unexpected mem_en inst %0d cycle %0d addr %h", g, cyc, mem_addr[g]);
    end else begin
      i = iq.pop_front();
      if (i.inst != g || i.cyc != cyc || i.we !== mem_we[g] || i.addr !== mem_addr[g] ||
          (i.we && i.wdata !== mem_wdata[g])) begin
        nerr++;
        $display("FAIL issue: got inst %0d cycle %0d we %0d addr %h wdata %h, expected inst %0d cycle %0d we %0d addr %h wdata %h",
                 g, cyc, mem_we[g], mem_addr[g], mem_wdata[g], i.inst, i.cyc, i.we, i.addr, i.wdata);
      end
    end
  endtask
  // monitor: pops expectations whenever a DUT presents an issue or a ready pulse
  always @(negedge clk)
    for (int g = 0; g < 3; g++) begin
      if (mem_en[g]) chk_issue(g);
      if (if_ready[g]) chk_ready(g, 1'b0, if_rdata[g]);
      if (d_ready[g]) chk_ready(g, 1'b1, d_rdata[g]);
      nvec++;
      if ((!if_ready[g] && if_rdata[g] !== 0) || (!d_ready[g] && d_rdata[g] !== 0)) begin
        nerr++;
        $display("FAIL idle_rdata: inst %0d cycle %0d if_rdata %h d_rdata %h, required 0", g, cyc, if_rdata[g], d_rdata[g]);
      end
    end
  task automatic chk_zero(int g, string tag);
    nvec++;
    if ({mem_en[g], mem_we[g], if_ready[g], d_ready[g], busy[g], grant_id[g],
         mem_addr[g], mem_wdata[g], if_rdata[g], d_rdata[g]} !== '0) begin
      nerr++;
      $display("FAIL %s: inst %0d en %0d we %0d rdy %0d/%0d busy %0d gid %0d addr %h wdata %h rdata %h/%h, required all 0",
               tag, g, mem_en[g], mem_we[g], if_ready[g], d_ready[g], busy[g], grant_id[g],
               mem_addr[g], mem_wdata[g], if_rdata[g], d_rdata[g]);
    end
  endtask
  task automatic single(int g, bit p, bit we, logic [31:0] a, logic [31:0] wd, logic [31:0] rd);
    int L, c, nb;
    L = g == 0 ? 2 : g == 1 ? 1 : 15;
    c = cyc;
    nb = 0;
    if (p) begin
      d_req[g] = 1; d_we[g] = we; d_addr[g] = a; d_wdata[g] = wd;
    end else begin
      if_req[g] = 1; if_addr[g] = a;
    end
    iq.push_back('{g, c + 1, p & we, a, wd});
    rq.push_back('{g, p, c + 1 + L, rd});
    for (int i = 0; i < 2 + L; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        d_we[g] = ~d_we[g]; d_addr[g] = ~a; d_wdata[g] = ~wd; if_addr[g] = ~a;
      end
      nb += int'(busy[g]);
    end
    if_req[g] = 0;
    d_req[g] = 0;
    nvec++;
    if (nb != 1 + L) begin
      nerr++;
      $display("FAIL busy_len: inst %0d busy for %0d cycles, required %0d", g, nb, 1 + L);
    end
  endtask
  task automatic collide();
    int c;
    bit [2:0] ord;
`ifdef UNIFIED_MEM_ARB_ROUND_ROBIN_EN
    ord = 3'b101;
`else
    ord = 3'b111;
`endif
    c = cyc;
    if_req[0] = 1; if_addr[0] = 32'h44;
    d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'h100;
    for (int k = 0; k < 3; k++) begin
      iq.push_back('{0, c + 1 + 4 * k, 1'b0, ord[k] ? 32'h100 : 32'h44, 32'h0});
      rq.push_back('{0, ord[k], c + 3 + 4 * k, ord[k] ? 32'h12345678 : 32'h00B00113});
    end
    repeat (12) @(posedge clk);
    #1;
    if_req[0] = 0;
    d_req[0] = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    int c;
    if_req = 0; d_req = 0; d_we = 0;
    for (int g = 0; g < 3; g++) begin
      if_addr[g] = 0; d_addr[g] = 0; d_wdata[g] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) chk_zero(g, "reset_values");
    reset = 1;
    @(posedge clk);
    #1;
    collide();
    single(0, 0, 0, 32'h40, 0, 32'h00A00093);
    single(0, 1, 0, 32'h100, 0, 32'h12345678);
    single(0, 1, 1, 32'h200, 32'hDEADBEEF, 32'h0);
    c = cyc;
    if_req[0] = 1; if_addr[0] = 32'h40;
    iq.push_back('{0, c + 1, 1'b0, 32'h40, 32'h0});
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (busy[0] !== 1'b1) begin
      nerr++;
      $display("FAIL pre_reset_busy: busy %0d, required 1", busy[0]);
    end
    reset = 0;
    if_req[0] = 0;
    #1;
    chk_zero(0, "reset_in_wait");
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    repeat (4) @(posedge clk);
    #1;
    single(0, 0, 0, 32'h80, 0, 32'hCAFEF00D);
    single(1, 0, 0, 32'h40, 0, 32'h00A00093);
    single(2, 1, 0, 32'h100, 0, 32'h12345678);
    single(1, 1, 1, 32'h300, 32'h0BADF00D, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    nvec++;
    if (rq.size() != 0 || iq.size() != 0) begin
      nerr++;
      $display("FAIL leftover: %0d ready and %0d issue expectations unmet, required 0", rq.size(), iq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-ported, fixed-latency unified memory between the pipelined CPU's instruction-fetch port (IF stage) and data port (MEM stage). It replaces the separate instruction and data memories. Each access is a request/ready transaction. The arbiter latches the winning request, issues it to memory, and waits out the memory latency. It then returns a one-cycle ready pulse to the owner; the CPU uses the missing ready as its stall condition.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LATENCY, 2, cycles from the issue cycle to valid mem_rdata; legal range is 1..15

Ports:
- clk  in  1  clock, all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  instruction read request; held high until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word; valid only while if_ready is high
- if_ready  out  1  one-cycle completion pulse for the fetch port
- d_req  in  1  data request; held high until d_ready
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  load data; valid while d_ready is high; 0 for writes
- d_ready  out  1  one-cycle completion pulse for the data port
- mem_en  out  1  memory issue strobe, one cycle per transaction
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after the mem_en cycle
- busy  out  1  high in ISSUE and WAIT
- grant_id  out  1  owner of the current or last transaction: 0 = IF, 1 = data

## Operation
- The FSM has three states: IDLE, ISSUE and WAIT.
- IDLE:
  - Both req inputs are sampled at the rising edge.
  - If either is high, the arbiter latches the winner's id, address, we and wdata, then moves to ISSUE.
  - Otherwise it stays in IDLE.
- Arbitration: d_req wins when both requests are high (fixed priority; see Configuration).
- ISSUE (one cycle):
  - mem_en=1.
  - mem_we, mem_addr and mem_wdata are driven from the latched registers.
  - IF transactions always drive mem_we=0.
  - The latency counter is loaded with MEM_LATENCY-1, and the FSM moves to WAIT.
- WAIT:
  - Lasts MEM_LATENCY cycles; the counter decrements each cycle.
  - In the cycle where the counter is 0, the owner's ready=1 and its rdata=mem_rdata (combinational pass-through; 0 for data writes).
  - The FSM then returns to IDLE.
- The non-owner's ready is 0 and its rdata is 0 throughout.
- A requester that drops req mid-transaction has no effect. The transaction completes, a write still happens, and ready still pulses.
- Inputs are latched at grant, so requester inputs may change freely after the grant edge.
- Reset asserted (low) at any time forces IDLE immediately and drives all outputs to 0. Any in-flight memory response is discarded.

## Timing
- Reset values: mem_en, mem_we, mem_addr, mem_wdata, if_ready, d_ready, if_rdata, d_rdata, busy and grant_id are all 0. The latency counter is 0 and the FSM is in IDLE.
- Request sampled high in IDLE cycle c:
  - mem_en is high in cycle c+1.
  - ready is high in cycle c+1+MEM_LATENCY.
  - Latency is therefore 1+MEM_LATENCY cycles.
- Throughput: one transaction per 2+MEM_LATENCY cycles. The cycle after ready is always IDLE, so back-to-back requests are never overlapped.
- The requester updates req at the edge that ends its ready cycle. If req is still high in the following IDLE cycle, it is a new request.
- Requests arriving during ISSUE or WAIT wait for IDLE. There is no queueing and no loss.

## Configuration
- Macro: UNIFIED_MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A last_grant register is kept; reset value is 0 (IF).
  - When both requests are high in IDLE, the port that did not win last is granted, so the data port wins the first collision after reset.
  - A single pending request is always granted immediately.
- Undefined: fixed data-over-IF priority; no last_grant register exists.

## Structure
- Package unified_mem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT)
  - the requester id constants REQ_IF=0 and REQ_D=1
  - the counter width constant, 4 bits
- Sub-module mem_lat_counter: a loadable down-counter with a zero flag, async active-low reset, and a load/enable interface. It is instantiated once.
- Everything else is in the top module.

## Test plan
- IF only, MEM_LATENCY=2: if_req=1, if_addr=0x40 in cycle 0; memory returns 0x00A00093. Expect mem_en and mem_addr=0x40 in cycle 1, then if_ready=1 and if_rdata=0x00A00093 in cycle 3.
- Simultaneous requests, macro undefined: if_req=1 and d_req=1 (read 0x100) every cycle for three transactions. Expect data granted every time and if_ready never high while d_req stays high.
- Simultaneous requests, macro defined: same stimulus. Expect grant order D, IF, D and ready pulses in cycles 3, 7 and 11.
- Data write: d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF. Expect mem_en=1, mem_we=1 and mem_wdata=0xDEADBEEF in cycle 1. Expect d_ready=1 with d_rdata=0 in cycle 3.
- Reset asserted low in a WAIT cycle (cycle 2) of an IF transaction. Expect all outputs 0 immediately and no if_ready after reset is released. The next request sampled in IDLE completes normally.
- MEM_LATENCY=1 and MEM_LATENCY=15 with a single read: expect ready in cycle 2 and cycle 16 respectively, and busy high for exactly 1+MEM_LATENCY cycles.
